// File: rtl/cache_line_array_pkg.sv
// Shared types for the direct-mapped cache line store: default widths, line and
// byte-enable types, the request record and the flush sequencer state.
package cache_def;

    localparam int LINE_W_DEF = 128;
    localparam int DEPTH_DEF  = 1024;
    localparam int TAG_W_DEF  = 18;
    localparam int IDX_W_DEF  = $clog2(DEPTH_DEF);
    localparam int BE_W_DEF   = LINE_W_DEF / 8;

    typedef logic [LINE_W_DEF-1:0] line_t;
    typedef logic [BE_W_DEF-1:0]   be_t;

    typedef struct packed {
        logic                 we;
        logic [IDX_W_DEF-1:0] index;
        logic [TAG_W_DEF-1:0] tag;
        be_t                  be;
        line_t                data;
    } cache_req_type;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } flush_state_e;

endpackage

// File: rtl/cache_line_array_if.sv
// Request/response bus between the load/store unit (master) and the cache line store (slave).
interface cache_line_array_if #(
    parameter int LINE_W = 128,
    parameter int TAG_W  = 18,
    parameter int IDX_W  = 10
);
    // A request transfers on a posedge where req_valid && req_ready; req_ready never
    // depends on req_valid, and rsp_valid pulses exactly one cycle after each transfer.
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [IDX_W-1:0]      req_index;
    logic [TAG_W-1:0]      req_tag;
    logic [LINE_W/8-1:0]   req_be;
    logic [LINE_W-1:0]     wdata;
    logic                  rsp_valid;
    logic                  rsp_hit;
    logic [LINE_W-1:0]     rdata;
    logic                  flush;
    logic                  flush_busy;

    modport master (
        output req_valid, req_we, req_index, req_tag, req_be, wdata, flush,
        input  req_ready, rsp_valid, rsp_hit, rdata, flush_busy
    );

    modport slave (
        input  req_valid, req_we, req_index, req_tag, req_be, wdata, flush,
        output req_ready, rsp_valid, rsp_hit, rdata, flush_busy
    );

endinterface

// File: rtl/cache_be_ram.sv
// Single-port byte-enable line RAM: synchronous write, combinational read, no reset.
module cache_be_ram #(
    parameter int  LINE_W = 128,
    parameter int  DEPTH  = 1024,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int BE_W   = LINE_W / 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [BE_W-1:0]   be,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/cache_line_array.sv
// Direct-mapped cache line store: data RAM plus per-line tag/valid, registered hit/miss
// response and a one-line-per-cycle flush sweep. Optional CACHE_LINE_ARRAY_STATS_EN adds hit/miss counters.
module cache_line_array
    import cache_def::*;
#(
    parameter int  LINE_W = LINE_W_DEF,
    parameter int  DEPTH  = DEPTH_DEF,
    parameter int  TAG_W  = TAG_W_DEF,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    cache_line_array_if.slave  bus,
    output flush_state_e       state_dbg
`ifdef CACHE_LINE_ARRAY_STATS_EN
    ,
    output logic [31:0]        stat_hits,
    output logic [31:0]        stat_misses
`endif
);

    localparam logic [IDX_W:0] LAST_IDX = (IDX_W + 1)'(DEPTH - 1);

    flush_state_e      state;
    logic [IDX_W:0]    sweep_cnt;
    logic [DEPTH-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_mem [DEPTH];
    logic [LINE_W-1:0] ram_rdata;
    logic [LINE_W-1:0] rdata_q;
    logic              rsp_valid_q;
    logic              rsp_hit_q;
    logic              accept;
    logic              lookup_hit;

    assign bus.req_ready  = rst_n && (state == IDLE) && !bus.flush;
    assign accept         = bus.req_valid && bus.req_ready;
    // Lookup sees the pre-write state, so a write reports the victim line it replaces.
    assign lookup_hit     = valid_q[bus.req_index] && (tag_mem[bus.req_index] == bus.req_tag);
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_hit    = rsp_hit_q;
    assign bus.rdata      = rdata_q;
    assign bus.flush_busy = (state == FLUSH);
    assign state_dbg      = state;

    cache_be_ram #(
        .LINE_W (LINE_W),
        .DEPTH  (DEPTH)
    ) u_data_ram (
        .clk   (clk),
        .we    (accept && bus.req_we),
        .addr  (bus.req_index),
        .be    (bus.req_be),
        .wdata (bus.wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (accept && bus.req_we) tag_mem[bus.req_index] <= bus.req_tag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sweep_cnt   <= '0;
            valid_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rdata_q     <= '0;
        end else begin
            rsp_valid_q <= accept;
            if (accept) begin
                rsp_hit_q <= lookup_hit;
                rdata_q   <= ram_rdata;
                if (bus.req_we) valid_q[bus.req_index] <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.flush) begin
                        state     <= FLUSH;
                        sweep_cnt <= '0;
                    end
                end
                FLUSH: begin
                    // Requests are blocked here, so the sweep never races a write to valid_q.
                    valid_q[sweep_cnt[IDX_W-1:0]] <= 1'b0;
                    sweep_cnt                     <= sweep_cnt + (IDX_W + 1)'(1);
                    if (sweep_cnt == LAST_IDX) state <= IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_LINE_ARRAY_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (state == IDLE && bus.flush) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (accept && !bus.req_we) begin
            if (lookup_hit) begin
                if (stat_hits != '1) stat_hits <= stat_hits + 32'd1;
            end else begin
                if (stat_misses != '1) stat_misses <= stat_misses + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_line_array.sv
// Bench for cache_line_array: directed cases, randomized traffic against an array-based
// reference model, flush timing and reset during flush.
module tb_cache_line_array;
  import cache_def::*;

  localparam int LW    = 128;
  localparam int DEPTH = 1024;
  localparam int TW    = 18;
  localparam int IW    = $clog2(DEPTH);
  localparam int BW    = LW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_line_array_if #(.LINE_W(LW), .TAG_W(TW), .IDX_W(IW)) bus();
  flush_state_e state_dbg;
`ifdef CACHE_LINE_ARRAY_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  cache_line_array #(.LINE_W(LW), .DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
`ifdef CACHE_LINE_ARRAY_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
`endif
  );

  // reference model: what each line should hold
  logic [LW-1:0] m_data  [DEPTH];
  logic [TW-1:0] m_tag   [DEPTH];
  bit            m_valid [DEPTH];
  bit            m_known [DEPTH];
  int unsigned   m_hits;
  int unsigned   m_misses;

  // scoreboard: {hit, rdata} per accepted request, plus whether rdata is defined
  logic [LW:0]   exp_q[$];
  bit            exp_chk_q[$];
  logic [LW-1:0] last_rdata;
  bit            last_known;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [LW:0] got, input logic [LW:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_stats();
`ifdef CACHE_LINE_ARRAY_STATS_EN
    check("stat_hits", stat_hits, m_hits);
    check("stat_misses", stat_misses, m_misses);
`endif
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_misses = 0;
    exp_q.delete();
    exp_chk_q.delete();
    last_rdata = '0;
    last_known = 1'b1;
  endtask

  task automatic model_flush();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_misses = 0;
  endtask

  // one clock: check the response owed from the previous cycle, then drive a new request
  task automatic step(input bit v, input bit we, input int idx, input logic [TW-1:0] tag,
                      input logic [BW-1:0] be, input logic [LW-1:0] wd);
    logic [LW:0] e;
    bit c;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      c = exp_chk_q.pop_front();
      check("rsp_valid", bus.rsp_valid, 1);
      check("rsp_hit", bus.rsp_hit, e[LW]);
      if (c) check("rdata", bus.rdata, e[LW-1:0]);
      last_rdata = e[LW-1:0];
      last_known = c;
    end else begin
      check("rsp_valid_idle", bus.rsp_valid, 0);
      if (last_known) check("rdata_hold", bus.rdata, last_rdata);
    end
    check("req_ready", bus.req_ready, 1);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_index = IW'(idx);
    bus.req_tag   = tag;
    bus.req_be    = be;
    bus.wdata     = wd;
    if (v) begin
      e[LW]      = m_valid[idx] && (m_tag[idx] == tag);
      e[LW-1:0]  = m_data[idx];
      exp_q.push_back(e);
      exp_chk_q.push_back(m_known[idx]);
      if (we) begin
        for (int b = 0; b < BW; b++) if (be[b]) m_data[idx][8*b +: 8] = wd[8*b +: 8];
        m_known[idx] = m_known[idx] || (be == '1);
        m_tag[idx]   = tag;
        m_valid[idx] = 1'b1;
      end else if (e[LW]) begin
        m_hits++;
      end else begin
        m_misses++;
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, '0, '0, '0);
  endtask

  // flush pulse with a read offered in the same cycle; the read must be refused
  task automatic start_flush(input int rd_idx);
    @(negedge clk);
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_index = IW'(rd_idx);
    #1;
    check("ready_on_flush", bus.req_ready, 0);
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    check("rsp_valid_flush", bus.rsp_valid, 0);
    check("flush_busy_entry", bus.flush_busy, 1);
    check("state_dbg_flush", state_dbg, FLUSH);
    check("ready_in_flush", bus.req_ready, 0);
    model_flush();
    check_stats();
  endtask

  int n;
  bit r_v, r_we;
  logic [BW-1:0] r_be;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_index = '0;
    bus.req_tag   = '0;
    bus.req_be    = '0;
    bus.wdata     = '0;
    bus.flush     = 1'b0;
    model_reset();

    // reset values
    repeat (3) @(negedge clk);
    check("reset_ready", bus.req_ready, 0);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_rsp_hit", bus.rsp_hit, 0);
    check("reset_rdata", bus.rdata, 0);
    check("reset_flush_busy", bus.flush_busy, 0);
    check("reset_state", state_dbg, IDLE);
    check_stats();
    rst_n = 1'b1;

    // cold read, full write, back-to-back hit, tag mismatch
    step(1'b1, 1'b0, 5, TW'(3), '0, '0);
    idle();
    step(1'b1, 1'b1, 5, TW'(3), '1, {BW{8'hAA}});
    step(1'b1, 1'b0, 5, TW'(3), '0, '0);
    step(1'b1, 1'b0, 5, TW'(4), '0, '0);
    // partial byte write over a zeroed line; write response shows pre-write data
    step(1'b1, 1'b1, 7, TW'(1), '1, '0);
    step(1'b1, 1'b1, 7, TW'(1), BW'(16'h0001), LW'(8'h55));
    step(1'b1, 1'b0, 7, TW'(1), '0, '0);
    step(1'b1, 1'b0, 7, TW'(1), '0, '0);
    idle();
    check_stats();

    // flush: exactly DEPTH busy cycles, a second flush pulse mid-sweep is ignored
    idle();
    start_flush(5);
    n = 1;
    while (n < 3000) begin
      @(negedge clk);
      bus.flush = (n == 10);
      if (!bus.flush_busy) break;
      n++;
    end
    bus.flush = 1'b0;
    check("flush_cycles", n, DEPTH);
    check("state_after_flush", state_dbg, IDLE);
    step(1'b1, 1'b0, 5, TW'(3), '0, '0);
    step(1'b1, 1'b0, 7, TW'(1), '0, '0);
    idle();
    check_stats();

    // randomized traffic over a small index window so lines collide often
    for (int i = 0; i < 16; i++)
      step(1'b1, 1'b1, i, TW'($urandom_range(0, 3)), '1, {$urandom(), $urandom(), $urandom(), $urandom()});
    for (int i = 0; i < 400; i++) begin
      r_v  = ($urandom_range(0, 9) != 0);
      r_we = ($urandom_range(0, 2) == 0);
      r_be = ($urandom_range(0, 7) == 0) ? '0 : BW'($urandom_range(0, 65535));
      step(r_v, r_we, $urandom_range(0, 15), TW'($urandom_range(0, 3)), r_be,
           {$urandom(), $urandom(), $urandom(), $urandom()});
    end
    idle();
    check_stats();

    // reset in the middle of a flush sweep
    idle();
    start_flush(3);
    repeat (99) @(negedge clk);
    check("busy_before_reset", bus.flush_busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst_flush_busy", bus.flush_busy, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_ready", bus.req_ready, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_state", state_dbg, IDLE);
    model_reset();
    check_stats();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, i, TW'($urandom_range(0, 3)), '0, '0);
    idle();
    check_stats();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
